counter_updown_bounded: RTL and testbench

//   N-bit up/down counter with programmable MIN/MAX bounds and selectable wrap or saturate mode.

---
 rtl/counter_updown_bounded.sv | 135 +++++++++++++
 tb/tb_counter_updown_bounded.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_bounded.sv
// counter_updown_bounded
// Up/down counter held inside the programmable range [MIN, MAX]. Each bound
// either wraps or saturates, selected by mode. Load takes priority over
// everything else and clamps its value into the range. When EDGE=1, up and
// down count only on their rising edge. carry and borrow are registered
// pulses that let counters be cascaded.
module counter_updown_bounded #(
  parameter int N    = 4,
  parameter int MIN  = 0,
  parameter int MAX  = (2 ** N) - 1,
  parameter int EDGE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         mode,
  output logic [N-1:0] o,
  output logic         carry,
  output logic         borrow,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [N-1:0] MIN_V = MIN[N-1:0];
  localparam logic [N-1:0] MAX_V = MAX[N-1:0];
  localparam logic [N-1:0] ONE_V = {{(N-1){1'b0}}, 1'b1};

  // Reject bound settings that could never keep the count in range.
  generate
    if ((MIN < 0) || (MIN >= MAX) || (MAX > ((2 ** N) - 1))) begin : g_param_err
      $error("counter_updown_bounded: need 0 <= MIN < MAX <= 2**N-1");
    end
  endgenerate

  logic [N-1:0] cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         up_hist_q, up_hist_d;
  logic         down_hist_q, down_hist_d;
  logic         u_s, d_s;
  logic [N-1:0] load_clamped_s;

  // Choose which form of request drives the counter: the raw level, or
  // only its rising edge.
  always_comb begin
    u_s = up;
    d_s = down;
    if (EDGE != 0) begin
      u_s = up & ~up_hist_q;
      d_s = down & ~down_hist_q;
    end else begin
      u_s = up;
      d_s = down;
    end
  end

  // Clamp the load value into [MIN, MAX]. Using inclusive compares keeps the
  // test valid when MIN is 0 and when MAX is the all-ones value.
  always_comb begin
    load_clamped_s = load_val;
    if (load_val >= MAX_V) begin
      load_clamped_s = MAX_V;
    end else if (load_val <= MIN_V) begin
      load_clamped_s = MIN_V;
    end else begin
      load_clamped_s = load_val;
    end
  end

  // Compute the next count and the wrap pulses. The bound checks happen
  // before the +/-1, so the addition or subtraction can never overflow N bits.
  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = 1'b0;
    borrow_d    = 1'b0;
    up_hist_d   = up;
    down_hist_d = down;
    if (load) begin
      cnt_d = load_clamped_s;
    end else if (!en) begin
      cnt_d = cnt_q;
    end else if (u_s && d_s) begin
      cnt_d = cnt_q;
    end else if (u_s) begin
      if (cnt_q != MAX_V) begin
        cnt_d = cnt_q + ONE_V;
      end else if (!mode) begin
        cnt_d   = MIN_V;
        carry_d = 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (d_s) begin
      if (cnt_q != MIN_V) begin
        cnt_d = cnt_q - ONE_V;
      end else if (!mode) begin
        cnt_d    = MAX_V;
        borrow_d = 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers. Reset is asynchronous: the count returns to MIN and any
  // pending pulse is cleared immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= MIN_V;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      up_hist_q   <= 1'b0;
      down_hist_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      up_hist_q   <= up_hist_d;
      down_hist_q <= down_hist_d;
    end
  end

  assign o      = cnt_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign at_max = (cnt_q == MAX_V);
  assign at_min = (cnt_q == MIN_V);

endmodule

// File: tb/tb_counter_updown_bounded.sv
// Directed bench for counter_updown_bounded. Four instances cover the
// configurations of interest, and all four share the same stimulus.
//   a: N=4 range 0..9  level requests
//   b: N=4 range 1..12 level requests
//   c: N=4 range 0..9  edge-qualified requests
//   d: N=8 range 0..255
module tb_counter_updown_bounded;

  logic       clk = 1'b0;
  logic       rst, en, up, down, load, mode;
  logic [7:0] lv8;

  logic [3:0] oa, ob, oc;
  logic [7:0] od;
  logic ca, ba, xa, na;
  logic cb, bb, xb, nb;
  logic cc, bc, xc, nc;
  logic cd, bd, xd, nd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_updown_bounded #(.N(4), .MIN(0), .MAX(9), .EDGE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(lv8[3:0]), .mode(mode), .o(oa), .carry(ca), .borrow(ba),
    .at_max(xa), .at_min(na));

  counter_updown_bounded #(.N(4), .MIN(1), .MAX(12), .EDGE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(lv8[3:0]), .mode(mode), .o(ob), .carry(cb), .borrow(bb),
    .at_max(xb), .at_min(nb));

  counter_updown_bounded #(.N(4), .MIN(0), .MAX(9), .EDGE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(lv8[3:0]), .mode(mode), .o(oc), .carry(cc), .borrow(bc),
    .at_max(xc), .at_min(nc));

  counter_updown_bounded #(.N(8), .MIN(0), .MAX(255), .EDGE(0)) u_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(lv8), .mode(mode), .o(od), .carry(cd), .borrow(bd),
    .at_max(xd), .at_min(nd));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset pulse.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; mode = 1'b0;
    lv8 = 8'd0;
    #12;
    chk("rst_oa", {4'd0, oa}, 8'd0);
    chk("rst_ob", {4'd0, ob}, 8'd1);
    chk("rst_ca", {7'd0, ca}, 8'd0);
    chk("rst_ba", {7'd0, ba}, 8'd0);
    chk("rst_at_min", {7'd0, na}, 8'd1);
    chk("rst_at_max", {7'd0, xa}, 8'd0);
    rst = 1'b0;

    // T1: wrap upward through 9 -> 0.
    en = 1'b1; up = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("t1_o", {4'd0, oa}, 8'(i % 10));
      chk("t1_carry", {7'd0, ca}, ((i % 10) == 0) ? 8'd1 : 8'd0);
      chk("t1_at_max", {7'd0, xa}, ((i % 10) == 9) ? 8'd1 : 8'd0);
    end
    up = 1'b0;

    // T2: saturate at both bounds.
    pulse_rst();
    chk("t2_rst_o", {4'd0, oa}, 8'd0);
    mode = 1'b1; down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_down_o", {4'd0, oa}, 8'd0);
      chk("t2_borrow", {7'd0, ba}, 8'd0);
      chk("t2_at_min", {7'd0, na}, 8'd1);
    end
    down = 1'b0; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("t2_up_o", {4'd0, oa}, (i > 9) ? 8'd9 : 8'(i));
      chk("t2_carry", {7'd0, ca}, 8'd0);
    end
    chk("t2_at_max", {7'd0, xa}, 8'd1);
    up = 1'b0;

    // T3: clamped load, then a downward wrap from MIN=1 to MAX=12.
    mode = 1'b0; load = 1'b1; lv8 = 8'd15;
    step();
    chk("t3_load_hi", {4'd0, ob}, 8'd12);
    chk("t3_at_max", {7'd0, xb}, 8'd1);
    lv8 = 8'd0;
    step();
    chk("t3_load_lo", {4'd0, ob}, 8'd1);
    chk("t3_at_min", {7'd0, nb}, 8'd1);
    lv8 = 8'd7;
    step();
    chk("t3_load_mid", {4'd0, ob}, 8'd7);
    lv8 = 8'd0;
    step();
    load = 1'b0; down = 1'b1;
    step();
    chk("t3_wrap_o", {4'd0, ob}, 8'd12);
    chk("t3_borrow", {7'd0, bb}, 8'd1);
    step();
    chk("t3_next_o", {4'd0, ob}, 8'd11);
    chk("t3_borrow_end", {7'd0, bb}, 8'd0);
    down = 1'b0;

    // T4: load beats en=0; up+down holds; en=0 holds.
    load = 1'b1; en = 1'b0; up = 1'b1; lv8 = 8'd5;
    step();
    chk("t4_load", {4'd0, oa}, 8'd5);
    load = 1'b0; en = 1'b1; up = 1'b1; down = 1'b1;
    step();
    chk("t4_both", {4'd0, oa}, 8'd5);
    en = 1'b0; down = 1'b0;
    step();
    chk("t4_en0", {4'd0, oa}, 8'd5);
    en = 1'b1;
    step();
    chk("t4_up", {4'd0, oa}, 8'd6);
    up = 1'b0; down = 1'b1;
    step();
    chk("t4_down", {4'd0, oa}, 8'd5);
    down = 1'b0;
    // Downward wrap in wrap mode on instance a.
    load = 1'b1; lv8 = 8'd0;
    step();
    load = 1'b0; down = 1'b1;
    step();
    chk("t4_wrap_o", {4'd0, oa}, 8'd9);
    chk("t4_borrow", {7'd0, ba}, 8'd1);
    down = 1'b0;

    // T5: edge-qualified requests on instance c.
    pulse_rst();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_held", {4'd0, oc}, 8'd1);
    end
    up = 1'b0;
    step();
    chk("t5_release", {4'd0, oc}, 8'd1);
    up = 1'b1;
    step();
    chk("t5_repress", {4'd0, oc}, 8'd2);
    up = 1'b0; en = 1'b0;
    step();
    up = 1'b1;
    step();
    chk("t5_en0", {4'd0, oc}, 8'd2);
    en = 1'b1;
    step();
    chk("t5_en_rise", {4'd0, oc}, 8'd2);
    up = 1'b0;

    // T6: 8-bit full-range wraps, then a mid-cycle reset clears the pulse.
    pulse_rst();
    load = 1'b1; lv8 = 8'd255;
    step();
    chk("t6_load", od, 8'd255);
    chk("t6_at_max", {7'd0, xd}, 8'd1);
    load = 1'b0; up = 1'b1;
    step();
    up = 1'b0;
    chk("t6_wrap_o", od, 8'd0);
    chk("t6_carry", {7'd0, cd}, 8'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_o", od, 8'd0);
    chk("t6_rst_carry", {7'd0, cd}, 8'd0);
    rst = 1'b0;
    down = 1'b1;
    step();
    down = 1'b0;
    chk("t6_bwrap_o", od, 8'd255);
    chk("t6_borrow", {7'd0, bd}, 8'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst2_o", od, 8'd0);
    chk("t6_rst2_borrow", {7'd0, bd}, 8'd0);
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
